// File: rtl/key_bank_pkg.sv
// Shared constants for the multi-channel key/LED bank: modes, keycode width,
// default keycode map and a small popcount helper.
package key_bank_pkg;

  localparam int KEY_W = 9;

  localparam logic [1:0] MODE_TOGGLE = 2'd0;
  localparam logic [1:0] MODE_MOMENT = 2'd1;
  localparam logic [1:0] MODE_RADIO  = 2'd2;

  // Channel 0 sits in the low bits: Enter, Space, '1', '2'.
  localparam logic [4*KEY_W-1:0] DEFAULT_KEYCODES = {9'h01E, 9'h016, 9'h029, 9'h05A};

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/key_press_tracker.sv
// Per-channel repeat suppressor: turns a stream of make codes (including
// typematic repeats) into a single accepted-press strobe per physical press.
module key_press_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic key_valid,
  input  logic key_match,
  input  logic key_bit,
  input  logic live_down,
  output logic accept
);

  logic held;

  assign accept = key_valid && key_match && key_bit && !held;

  // A live key_down of 0 also clears held, so a dropped break code cannot
  // lock the channel out forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= 1'b0;
    end else if (accept) begin
      held <= 1'b1;
    end else if ((key_valid && key_match && !key_bit) || !live_down) begin
      held <= 1'b0;
    end
  end

endmodule

// File: rtl/key_toggle_bank.sv
// Maps NUM_CH keycodes from the PS/2 decoder onto NUM_CH LEDs with toggle,
// momentary and radio modes, plus a saturating count of accepted presses.
module key_toggle_bank
  import key_bank_pkg::*;
#(
  parameter int                          NUM_CH   = 4,
  parameter logic [NUM_CH*KEY_W-1:0]     KEYCODES = DEFAULT_KEYCODES,
  parameter int                          CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  input  logic [511:0]       key_down,
  input  logic [KEY_W-1:0]   last_change,
  input  logic [1:0]         mode,
  input  logic               clear,
  output logic [NUM_CH-1:0]  led,
  output logic [NUM_CH-1:0]  press_pulse,
  output logic [CNT_W-1:0]   press_count
);

  localparam int SUM_W = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        mode_q;
  logic              key_bit;
  logic [NUM_CH-1:0] key_match;
  logic [NUM_CH-1:0] live_down;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] radio_sel;
  logic [NUM_CH-1:0] led_next;
  logic [4:0]        pop;
  logic [SUM_W-1:0]  cnt_sum;
  logic [CNT_W-1:0]  cnt_next;

  assign key_bit = key_down[last_change];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign key_match[g] = (last_change == KEYCODES[g*KEY_W +: KEY_W]);
    assign live_down[g] = key_down[KEYCODES[g*KEY_W +: KEY_W]];

    key_press_tracker u_tracker (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_match (key_match[g]),
      .key_bit   (key_bit),
      .live_down (live_down[g]),
      .accept    (accept[g])
    );
  end

  // Duplicate keycodes can accept on several channels at once; radio mode
  // lights only the lowest of them.
  always_comb begin
    logic found;
    radio_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept[i] && !found) begin
        radio_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    led_next = led;
    if (clear || (mode != mode_q)) begin
      led_next = '0;
    end else begin
      case (mode_q)
        MODE_MOMENT: led_next = live_down;
        MODE_RADIO:  if (|accept) led_next = radio_sel;
        MODE_TOGGLE: led_next = led ^ accept;
        default:     led_next = led ^ accept;
      endcase
    end
  end

  always_comb begin
    pop      = popcount16(16'(accept));
    cnt_sum  = SUM_W'(press_count) + SUM_W'(pop);
    cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led         <= '0;
      press_pulse <= '0;
      press_count <= '0;
      mode_q      <= MODE_TOGGLE;
    end else begin
      led         <= led_next;
      press_pulse <= accept;
      press_count <= clear ? '0 : cnt_next;
      mode_q      <= mode;
    end
  end

endmodule

// File: tb/tb_key_toggle_bank.sv
// Directed bench for key_toggle_bank: a vector table for the main modes plus
// hand sequences for momentary hold, counter saturation and async reset.
module tb_key_toggle_bank;
  import key_bank_pkg::*;

  localparam logic [35:0] CODES = {9'h01E, 9'h016, 9'h029, 9'h05A};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         key_valid = 1'b0;
  logic [511:0] key_down = '0;
  logic [8:0]   last_change = '0;
  logic [1:0]   mode = 2'd0;
  logic         clear = 1'b0;
  logic [3:0]   led, press_pulse, led_s, pulse_s;
  logic [7:0]   press_count;
  logic [3:0]   cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_toggle_bank #(.NUM_CH(4), .KEYCODES(CODES), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_down(key_down),
    .last_change(last_change), .mode(mode), .clear(clear),
    .led(led), .press_pulse(press_pulse), .press_count(press_count)
  );

  key_toggle_bank #(.NUM_CH(4), .KEYCODES(CODES), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_down(key_down),
    .last_change(last_change), .mode(mode), .clear(clear),
    .led(led_s), .press_pulse(pulse_s), .press_count(cnt_s)
  );

  typedef struct {
    string      name;
    logic       kv;
    logic [8:0] lc;
    logic [3:0] down;
    logic [1:0] md;
    logic       clr;
    logic [3:0] e_led;
    logic [3:0] e_pulse;
    int         e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string name, input logic kv, input logic [8:0] lc,
                        input logic [3:0] down, input logic [1:0] md, input logic clr,
                        input logic [3:0] e_led, input logic [3:0] e_pulse, input int e_cnt);
    vec_t v;
    v.name = name; v.kv = kv; v.lc = lc; v.down = down; v.md = md; v.clr = clr;
    v.e_led = e_led; v.e_pulse = e_pulse; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic kv, input logic [8:0] lc, input logic [3:0] down,
                               input logic [1:0] md, input logic clr);
    logic [35:0] codes;
    codes = CODES;
    key_valid   = kv;
    last_change = lc;
    mode        = md;
    clear       = clr;
    key_down    = '0;
    for (int i = 0; i < 4; i++) begin
      if (down[i]) key_down[codes[9*i +: 9]] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_led,
                             input logic [3:0] e_pulse, input int e_cnt);
    logic [3:0] e_sat;
    e_sat = (e_cnt > 15) ? 4'd15 : 4'(e_cnt);
    checks++;
    if (led !== e_led) begin
      errors++;
      $display("[TB] FAIL %s led: got %b expected %b", name, led, e_led);
    end
    checks++;
    if (press_pulse !== e_pulse) begin
      errors++;
      $display("[TB] FAIL %s press_pulse: got %b expected %b", name, press_pulse, e_pulse);
    end
    checks++;
    if (press_count !== 8'(e_cnt)) begin
      errors++;
      $display("[TB] FAIL %s press_count: got %0d expected %0d", name, press_count, e_cnt);
    end
    checks++;
    if (cnt_s !== e_sat) begin
      errors++;
      $display("[TB] FAIL %s sat_count: got %0d expected %0d", name, cnt_s, e_sat);
    end
  endtask

  task automatic step(input string name, input logic kv, input logic [8:0] lc,
                      input logic [3:0] down, input logic [1:0] md, input logic clr,
                      input logic [3:0] e_led, input logic [3:0] e_pulse, input int e_cnt);
    applyStimulus(kv, lc, down, md, clr);
    checkOutput(name, e_led, e_pulse, e_cnt);
  endtask

  initial begin
    // Toggle mode, repeat suppression
    addVec("idle",      0, 9'h000, 4'b0000, 2'd0, 0, 4'b0000, 4'b0000, 0);
    addVec("t_make0",   1, 9'h05A, 4'b0001, 2'd0, 0, 4'b0001, 4'b0001, 1);
    addVec("t_hold",    0, 9'h05A, 4'b0001, 2'd0, 0, 4'b0001, 4'b0000, 1);
    addVec("t_rep1",    1, 9'h05A, 4'b0001, 2'd0, 0, 4'b0001, 4'b0000, 1);
    addVec("t_rep2",    1, 9'h05A, 4'b0001, 2'd0, 0, 4'b0001, 4'b0000, 1);
    addVec("t_rep3",    1, 9'h05A, 4'b0001, 2'd0, 0, 4'b0001, 4'b0000, 1);
    addVec("t_break",   1, 9'h05A, 4'b0000, 2'd0, 0, 4'b0001, 4'b0000, 1);
    addVec("t_make0b",  1, 9'h05A, 4'b0001, 2'd0, 0, 4'b0000, 4'b0001, 2);
    addVec("t_rel0",    1, 9'h05A, 4'b0000, 2'd0, 0, 4'b0000, 4'b0000, 2);
    addVec("t_on0",     1, 9'h05A, 4'b0001, 2'd0, 0, 4'b0001, 4'b0001, 3);
    addVec("t_on1",     1, 9'h029, 4'b0011, 2'd0, 0, 4'b0011, 4'b0010, 4);
    addVec("t_lostbrk", 0, 9'h029, 4'b0000, 2'd0, 0, 4'b0011, 4'b0000, 4);
    // Mode switch into radio
    addVec("sw_radio",  0, 9'h029, 4'b0000, 2'd2, 0, 4'b0000, 4'b0000, 4);
    addVec("r_ch2",     1, 9'h016, 4'b0100, 2'd2, 0, 4'b0100, 4'b0100, 5);
    addVec("r_rel2",    1, 9'h016, 4'b0000, 2'd2, 0, 4'b0100, 4'b0000, 5);
    addVec("r_ch0",     1, 9'h05A, 4'b0001, 2'd2, 0, 4'b0001, 4'b0001, 6);
    addVec("r_rel0",    1, 9'h05A, 4'b0000, 2'd2, 0, 4'b0001, 4'b0000, 6);
    addVec("r_ch0again",1, 9'h05A, 4'b0001, 2'd2, 0, 4'b0001, 4'b0001, 7);
    addVec("r_rel0b",   1, 9'h05A, 4'b0000, 2'd2, 0, 4'b0001, 4'b0000, 7);
    // Press in the same cycle as a mode change counts but leaves led cleared
    addVec("sw_press",  1, 9'h029, 4'b0010, 2'd0, 0, 4'b0000, 4'b0010, 8);
    addVec("sw_rel",    1, 9'h029, 4'b0000, 2'd0, 0, 4'b0000, 4'b0000, 8);
    // Clear beats a simultaneous press, which still pulses and sets held
    addVec("c_on0",     1, 9'h05A, 4'b0001, 2'd0, 0, 4'b0001, 4'b0001, 9);
    addVec("c_press3",  1, 9'h01E, 4'b1001, 2'd0, 1, 4'b0000, 4'b1000, 0);
    addVec("c_after",   0, 9'h01E, 4'b1001, 2'd0, 0, 4'b0000, 4'b0000, 0);
    addVec("c_rep3",    1, 9'h01E, 4'b1001, 2'd0, 0, 4'b0000, 4'b0000, 0);
    addVec("c_relall",  0, 9'h01E, 4'b0000, 2'd0, 0, 4'b0000, 4'b0000, 0);
    // Momentary entry
    addVec("sw_mom",    0, 9'h000, 4'b0000, 2'd1, 0, 4'b0000, 4'b0000, 0);
    addVec("m_make1",   1, 9'h029, 4'b0010, 2'd1, 0, 4'b0010, 4'b0010, 1);

    #2 rst_n = 1'b0;
    #1 checkOutput("reset", 4'b0000, 4'b0000, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].name, vecs[i].kv, vecs[i].lc, vecs[i].down, vecs[i].md, vecs[i].clr,
           vecs[i].e_led, vecs[i].e_pulse, vecs[i].e_cnt);
    end

    // Momentary hold: ten cycles lit in total, single pulse
    for (int i = 0; i < 9; i++) begin
      step("m_hold", 0, 9'h029, 4'b0010, 2'd1, 0, 4'b0010, 4'b0000, 1);
    end
    step("m_release",  1, 9'h029, 4'b0000, 2'd1, 0, 4'b0000, 4'b0000, 1);
    step("m_nokv",     0, 9'h000, 4'b0100, 2'd1, 0, 4'b0100, 4'b0000, 1);
    step("m_clear",    0, 9'h000, 4'b0100, 2'd1, 1, 4'b0000, 4'b0000, 0);
    step("m_resume",   0, 9'h000, 4'b0100, 2'd1, 0, 4'b0100, 4'b0000, 0);
    step("m_off",      0, 9'h000, 4'b0000, 2'd1, 0, 4'b0000, 4'b0000, 0);

    // Saturation: the 4-bit instance must stop at 15
    step("s_start", 0, 9'h000, 4'b0000, 2'd0, 1, 4'b0000, 4'b0000, 0);
    for (int k = 1; k <= 20; k++) begin
      step("s_make",  1, 9'h05A, 4'b0001, 2'd0, 0, (k % 2 == 1) ? 4'b0001 : 4'b0000, 4'b0001, k);
      step("s_break", 1, 9'h05A, 4'b0000, 2'd0, 0, (k % 2 == 1) ? 4'b0001 : 4'b0000, 4'b0000, k);
    end
    for (int i = 0; i < 3; i++) begin
      step("s_hold", 0, 9'h000, 4'b0000, 2'd0, 0, 4'b0000, 4'b0000, 20);
    end

    // Async reset while a key is held, then a repeat make counts anew
    step("a_make",  1, 9'h05A, 4'b0001, 2'd0, 0, 4'b0001, 4'b0001, 21);
    step("a_hold",  0, 9'h05A, 4'b0001, 2'd0, 0, 4'b0001, 4'b0000, 21);
    rst_n = 1'b0;
    #1 checkOutput("a_async", 4'b0000, 4'b0000, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("a_idle",  0, 9'h05A, 4'b0001, 2'd0, 0, 4'b0000, 4'b0000, 0);
    step("a_remake",1, 9'h05A, 4'b0001, 2'd0, 0, 4'b0001, 4'b0001, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
